// File: rtl/alu_pkg.sv
// Shared ALU encodings and the ID->EX held-op payload.
// Holds XLEN / RADDR_W, the ALUctr codes, the operand-select enums, the
// packed held-op struct and a small writer-match helper.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CTR_W   = 5;

    // ALUctr = {f7[5], f7[0], f3}
    localparam logic [CTR_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [CTR_W-1:0] ALU_SLL  = 5'b00001;
    localparam logic [CTR_W-1:0] ALU_SLT  = 5'b00010;
    localparam logic [CTR_W-1:0] ALU_SLTU = 5'b00011;
    localparam logic [CTR_W-1:0] ALU_XOR  = 5'b00100;
    localparam logic [CTR_W-1:0] ALU_SRL  = 5'b00101;
    localparam logic [CTR_W-1:0] ALU_OR   = 5'b00110;
    localparam logic [CTR_W-1:0] ALU_AND  = 5'b00111;
    localparam logic [CTR_W-1:0] ALU_SUB  = 5'b10000;
    localparam logic [CTR_W-1:0] ALU_SRA  = 5'b10101;
    localparam logic [CTR_W-1:0] ALU_LUI  = 5'b11000;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2,
        A_RSV  = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2,
        B_RSV  = 2'd3
    } b_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        a_sel_e             a_sel;
        b_sel_e             b_sel;
        logic [CTR_W-1:0]   alu_ctr;
        logic [RADDR_W-1:0] rd;
        logic               is_load;
    } issue_op_t;

    // A writer hits a source only for a nonzero index; x0 is never hazarded.
    function automatic logic wr_hit(input logic en, input logic [RADDR_W-1:0] wr_rd,
                                    input logic [RADDR_W-1:0] rs);
        return en && (rs != '0) && (wr_rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand of the held op.
// Ports: used/rs/stored describe the held source; mem_* and wb_* are the
// downstream writers; data is the resolved value, stall flags a load-use.
// With EX_FWD_EN defined: mem > wb > stored, stall on a mem hit whose result
// is not yet available. Without it: stored data only, never stalls.
module operand_fwd_mux
    import alu_pkg::*;
(
    input  logic               used,
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    stored,
    input  logic               mem_wr_en,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_data_vld,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               wb_wr_en,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    data,
    output logic               stall
);

`ifdef EX_FWD_EN
    // Youngest writer wins.
    always_comb begin
        data  = stored;
        stall = 1'b0;
        if (used && wr_hit(mem_wr_en, mem_rd, rs)) begin
            data  = mem_data;
            stall = !mem_data_vld;
        end else if (used && wr_hit(wb_wr_en, wb_rd, rs)) begin
            data  = wb_data;
        end
    end
`else
    logic unused_fwd;

    assign data       = stored;
    assign stall      = 1'b0;
    assign unused_fwd = ^{used, rs, mem_wr_en, mem_rd, mem_data_vld, mem_data,
                          wb_wr_en, wb_rd, wb_data};
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// ID->EX pipeline register feeding the ALU.
// Ports: clk/rst_n; flush; in_* valid/ready op capture from ID; mem_* and
// wb_* downstream writer snoop; out_valid/out_ready handshake to EX/MEM with
// da/db/alu_ctr operands and out_rd/out_is_load/out_pc pass-through.
// Macro EX_FWD_EN: defined enables mem/wb forwarding with load-use stall;
// undefined blocks capture while any source has a pending writer.
module ex_issue_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [1:0]         in_a_sel,
    input  logic [1:0]         in_b_sel,
    input  logic [CTR_W-1:0]   in_alu_ctr,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_is_load,
    input  logic               mem_wr_en,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_data_vld,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               wb_wr_en,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    da,
    output logic [XLEN-1:0]    db,
    output logic [CTR_W-1:0]   alu_ctr,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_is_load,
    output logic [XLEN-1:0]    out_pc
);

    issue_op_t       op_q, op_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            stall1, stall2, load_use;
    logic            use1_q, use2_q, use1_in, use2_in;
    logic            fire, accept, blocked;

    assign use1_q  = (op_q.a_sel == A_RS1);
    assign use2_q  = (op_q.b_sel == B_RS2);
    assign use1_in = (in_a_sel == A_RS1);
    assign use2_in = (in_b_sel == B_RS2);

    operand_fwd_mux u_fwd_rs1 (
        .used(use1_q), .rs(op_q.rs1), .stored(op_q.rs1_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data_vld(mem_data_vld), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .data(rs1_val), .stall(stall1)
    );

    operand_fwd_mux u_fwd_rs2 (
        .used(use2_q), .rs(op_q.rs2), .stored(op_q.rs2_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data_vld(mem_data_vld), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .data(rs2_val), .stall(stall2)
    );

    assign load_use = stall1 || stall2;

`ifdef EX_FWD_EN
    assign blocked = 1'b0;
`else
    // Held op, mem and wb are all writers whose result is not yet in the regfile.
    assign blocked = in_valid && (
        (use1_in && (wr_hit(valid_q, op_q.rd, in_rs1) || wr_hit(mem_wr_en, mem_rd, in_rs1) ||
                     wr_hit(wb_wr_en, wb_rd, in_rs1))) ||
        (use2_in && (wr_hit(valid_q, op_q.rd, in_rs2) || wr_hit(mem_wr_en, mem_rd, in_rs2) ||
                     wr_hit(wb_wr_en, wb_rd, in_rs2))));
`endif

    assign out_valid = valid_q && !load_use;
    assign fire      = out_valid && out_ready;
    assign in_ready  = (!valid_q || fire) && !blocked;
    assign accept    = in_valid && in_ready && !flush;

    // Next held op: flush > accept > leave > snoop wb into stored sources.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d          = 1'b1;
            op_d.pc          = in_pc;
            op_d.rs1         = in_rs1;
            op_d.rs2         = in_rs2;
            op_d.rs1_data    = (use1_in && wr_hit(wb_wr_en, wb_rd, in_rs1)) ? wb_data : in_rs1_data;
            op_d.rs2_data    = (use2_in && wr_hit(wb_wr_en, wb_rd, in_rs2)) ? wb_data : in_rs2_data;
            op_d.imm         = in_imm;
            op_d.a_sel       = a_sel_e'(in_a_sel);
            op_d.b_sel       = b_sel_e'(in_b_sel);
            op_d.alu_ctr     = in_alu_ctr;
            op_d.rd          = in_rd;
            op_d.is_load     = in_is_load;
        end else if (fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (use1_q && wr_hit(wb_wr_en, wb_rd, op_q.rs1)) op_d.rs1_data = wb_data;
            if (use2_q && wr_hit(wb_wr_en, wb_rd, op_q.rs2)) op_d.rs2_data = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
        end
    end

    // Operand select; reserved encodings read as zero.
    always_comb begin
        da = '0;
        db = '0;
        case (op_q.a_sel)
            A_RS1:   da = rs1_val;
            A_PC:    da = op_q.pc;
            default: da = '0;
        endcase
        case (op_q.b_sel)
            B_RS2:   db = rs2_val;
            B_IMM:   db = op_q.imm;
            B_FOUR:  db = XLEN'(4);
            default: db = '0;
        endcase
    end

    assign alu_ctr     = op_q.alu_ctr;
    assign out_rd      = op_q.rd;
    assign out_is_load = op_q.is_load;
    assign out_pc      = op_q.pc;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural held-op model. Works with EX_FWD_EN defined or undefined.
module tb_ex_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic [1:0]  in_a_sel = '0, in_b_sel = '0;
    logic [4:0]  in_alu_ctr = '0;
    logic [4:0]  in_rd = '0;
    logic        in_is_load = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic        mem_data_vld = 1'b1;
    logic [31:0] mem_data = '0;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] da, db;
    logic [4:0]  alu_ctr;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic [31:0] out_pc;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_ctr(in_alu_ctr),
        .in_rd(in_rd), .in_is_load(in_is_load),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data_vld(mem_data_vld), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .da(da), .db(db), .alu_ctr(alu_ctr),
        .out_rd(out_rd), .out_is_load(out_is_load), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0, m_ctr = '0;
    logic [1:0]  m_as = '0, m_bs = '0;
    bit          m_ld = 1'b0;

    // Value a held source actually sees this cycle, and whether it must wait.
    function automatic void resolve(input logic [4:0] rs, input bit used, input logic [31:0] stored,
                                    output logic [31:0] v, output bit s);
        v = stored;
        s = 1'b0;
        if (FWD && used && rs != 0) begin
            if (mem_wr_en && mem_rd == rs) begin
                v = mem_data;
                s = !mem_data_vld;
            end else if (wb_wr_en && wb_rd == rs) begin
                v = wb_data;
            end
        end
    endfunction

    function automatic bit pending(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        return (m_valid && m_rd == rs) || (mem_wr_en && mem_rd == rs) || (wb_wr_en && wb_rd == rs);
    endfunction

    function automatic bit wb_writes(input logic [4:0] rs);
        return wb_wr_en && rs != 0 && wb_rd == rs;
    endfunction

    // Single compare process: every cycle, mid-period, while inputs are stable.
    always @(negedge clk) begin : compare
        logic [31:0] v1, v2, ea, eb;
        bit s1, s2, eov, eir, fires, acc, blk;
        if (!rst_n) begin
            m_valid = 1'b0;
        end
        resolve(m_rs1, m_as == 2'd0, m_d1, v1, s1);
        resolve(m_rs2, m_bs == 2'd0, m_d2, v2, s2);
        eov   = m_valid && !(s1 || s2);
        fires = eov && out_ready;
        blk   = !FWD && in_valid && ((in_a_sel == 2'd0 && pending(in_rs1)) ||
                                     (in_b_sel == 2'd0 && pending(in_rs2)));
        eir   = (!m_valid || fires) && !blk;
        acc   = in_valid && eir && !flush;
        ea = (m_as == 2'd0) ? v1 : (m_as == 2'd1) ? m_pc : 32'd0;
        eb = (m_bs == 2'd0) ? v2 : (m_bs == 2'd1) ? m_imm : (m_bs == 2'd2) ? 32'd4 : 32'd0;
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("in_ready", 32'(in_ready), 32'(eir));
        if (eov) begin
            chk("da", da, ea);
            chk("db", db, eb);
            chk("alu_ctr", 32'(alu_ctr), 32'(m_ctr));
            chk("out_rd", 32'(out_rd), 32'(m_rd));
            chk("out_is_load", 32'(out_is_load), 32'(m_ld));
            chk("out_pc", out_pc, m_pc);
        end
        if (rst_n) begin
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_pc = in_pc; m_rs1 = in_rs1; m_rs2 = in_rs2; m_imm = in_imm;
                m_as = in_a_sel; m_bs = in_b_sel; m_ctr = in_alu_ctr; m_rd = in_rd; m_ld = in_is_load;
                m_d1 = (in_a_sel == 2'd0 && wb_writes(in_rs1)) ? wb_data : in_rs1_data;
                m_d2 = (in_b_sel == 2'd0 && wb_writes(in_rs2)) ? wb_data : in_rs2_data;
            end else if (fires) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (m_as == 2'd0 && wb_writes(m_rs1)) m_d1 = wb_data;
                if (m_bs == 2'd0 && wb_writes(m_rs2)) m_d2 = wb_data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; mem_wr_en = 0; wb_wr_en = 0; mem_data_vld = 1; out_ready = 1;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [1:0] as, input logic [1:0] bs, input logic [4:0] rd);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
        in_imm = imm; in_a_sel = as; in_b_sel = bs; in_alu_ctr = ALU_ADD; in_rd = rd; in_is_load = 0;
    endtask

    logic [4:0] ctr_tab [11];

    initial begin
        ctr_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
                    ALU_OR, ALU_AND, ALU_SUB, ALU_SRA, ALU_LUI};
        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset da", da, 32'd0);
        chk("reset db", db, 32'd0);
        chk("reset alu_ctr", 32'(alu_ctr), 32'd0);
        tick();
        rst_n = 1;
        tick();

        // Back-to-back ADDs, full throughput.
        idle();
        set_op(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 2'd0, 2'd0, 5'd10);
        #1 chk("t1 in_ready", 32'(in_ready), 32'd1);
        tick();
        set_op(32'h104, 5'd3, 32'h33, 5'd6, 32'h66, 32'h0, 2'd0, 2'd0, 5'd11);
        #1;
        chk("t1 ov0", 32'(out_valid), 32'd1);
        chk("t1 da0", da, 32'h11);
        chk("t1 db0", db, 32'h22);
        chk("t1 pc0", out_pc, 32'h100);
        chk("t1 ir", 32'(in_ready), 32'd1);
        tick();
        in_valid = 0;
        #1;
        chk("t1 da1", da, 32'h33);
        chk("t1 db1", db, 32'h66);
        tick();
        #1 chk("t1 drained", 32'(out_valid), 32'd0);

        // Back-pressure while wb updates the held rs1.
        set_op(32'h200, 5'd3, 32'h10, 5'd0, 32'h0, 32'h8, 2'd0, 2'd1, 5'd12);
        out_ready = 0;
        tick();
        in_valid = 0; wb_wr_en = 1; wb_rd = 5'd3; wb_data = 32'h55;
        tick();
        wb_wr_en = 0;
        tick();
        tick();
        out_ready = 1;
        #1;
        chk("t4 ov", 32'(out_valid), 32'd1);
        chk("t4 da", da, 32'h55);
        chk("t4 db", db, 32'h8);
        tick();
        #1 chk("t4 no dup", 32'(out_valid), 32'd0);

        // Flush with a held op and a new op offered.
        set_op(32'h300, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 2'd0, 2'd0, 5'd13);
        out_ready = 0;
        tick();
        set_op(32'h304, 5'd8, 32'h8, 5'd9, 32'h9, 32'h0, 2'd0, 2'd0, 5'd14);
        flush = 1;
        tick();
        idle();
        #1 chk("t5 ov after flush", 32'(out_valid), 32'd0);
        tick();
        #1 chk("t5 still empty", 32'(out_valid), 32'd0);

`ifdef EX_FWD_EN
        // mem forward beats wb.
        set_op(32'h400, 5'd5, 32'h1, 5'd0, 32'h0, 32'h0, 2'd0, 2'd2, 5'd15);
        out_ready = 0;
        tick();
        in_valid = 0;
        mem_wr_en = 1; mem_rd = 5'd5; mem_data = 32'hDEAD; mem_data_vld = 1;
        wb_wr_en = 1; wb_rd = 5'd5; wb_data = 32'hBEEF;
        #1;
        chk("t2 da", da, 32'hDEAD);
        chk("t2 db", db, 32'd4);
        tick();
        idle();
        tick();

        // Load-use stall for two cycles.
        set_op(32'h500, 5'd0, 32'h0, 5'd7, 32'h2, 32'h0, 2'd2, 2'd0, 5'd16);
        tick();
        set_op(32'h504, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 2'd0, 2'd0, 5'd17);
        mem_wr_en = 1; mem_rd = 5'd7; mem_data_vld = 0; mem_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3 ov stall", 32'(out_valid), 32'd0);
            chk("t3 ir stall", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 0; mem_data_vld = 1; mem_data = 32'h1234;
        #1;
        chk("t3 ov", 32'(out_valid), 32'd1);
        chk("t3 db", db, 32'h1234);
        tick();
        idle();
        tick();
`else
        // Capture blocked until the rd=4 writer has retired through wb.
        set_op(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 2'd0, 2'd0, 5'd4);
        out_ready = 0;
        tick();
        set_op(32'h604, 5'd4, 32'h44, 5'd0, 32'h0, 32'h3, 2'd0, 2'd1, 5'd18);
        #1 chk("t6 ir held", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1;
        #1 chk("t6 ir leaving", 32'(in_ready), 32'd0);
        tick();
        mem_wr_en = 1; mem_rd = 5'd4;
        #1 chk("t6 ir mem", 32'(in_ready), 32'd0);
        tick();
        mem_wr_en = 0; wb_wr_en = 1; wb_rd = 5'd4; wb_data = 32'h77;
        #1 chk("t6 ir wb", 32'(in_ready), 32'd0);
        tick();
        wb_wr_en = 0; in_rs1_data = 32'h77;
        #1 chk("t6 ir free", 32'(in_ready), 32'd1);
        tick();
        in_valid = 0;
        #1;
        chk("t6 ov", 32'(out_valid), 32'd1);
        chk("t6 da", da, 32'h77);
        tick();
        idle();
        tick();
`endif

        // Randomized traffic with a mid-run async reset.
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 15) == 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            in_pc        = $urandom;
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_rs1_data  = $urandom;
            in_rs2_data  = $urandom;
            in_imm       = $urandom;
            in_a_sel     = 2'($urandom_range(0, 3));
            in_b_sel     = 2'($urandom_range(0, 3));
            in_alu_ctr   = ctr_tab[$urandom_range(0, 10)];
            in_rd        = 5'($urandom_range(0, 7));
            in_is_load   = 1'($urandom_range(0, 1));
            mem_wr_en    = ($urandom_range(0, 9) < 4);
            mem_rd       = 5'($urandom_range(0, 7));
            mem_data_vld = ($urandom_range(0, 3) != 0);
            mem_data     = $urandom;
            wb_wr_en     = ($urandom_range(0, 1) == 1);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            if (i == 1500) rst_n = 0;
            if (i == 1501) rst_n = 1;
            tick();
        end
        idle();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
